gnn_0_example_save: RTL and testbench

Result store engine: the write-direction counterpart of the weight/feature loaders. On an instruction it reads consecutive 16×512-bit words from an on-chip buffer and serialises each into sixteen 512-bit beats, lowest slice first. It streams them to an external AXI4 write master and then reports completion to the ctrl module. It sits between the output buffer read port and the kernel's AXI write master.

---
 rtl/gnn_0_example_save.sv | 154 +++++++++++++++
 tb/tb_gnn_0_example_save.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_0_example_save.sv
// rtl/gnn_0_example_save.sv - result store engine: buffer words serialised to a 512-bit beat stream
module gnn_0_example_save #(
  parameter int SAVE_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                             kernel_clk,
  input  logic                             kernel_rst_n,
  input  logic                             ap_start,
  output logic                             ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]    ctrl_addr_offset,
  input  logic [SAVE_INST_LENGTH-1:0]      ctrl_instruction,
  output logic                             save_read_buffer_r_en,
  output logic [12:0]                      save_read_buffer_r_addr,
  input  logic [16*C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_r_data,
  output logic                             wr_ctrl_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]    wr_ctrl_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]     wr_ctrl_xfer_size_in_bytes,
  input  logic                             wr_ctrl_done,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                             m_axis_tlast
);

  localparam int BUF_W = 16 * C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_FETCH, S_CAPTURE, S_SEND, S_WAIT_WR, S_DONE
  } state_t;

  state_t                          r_state;
  logic [12:0]                     r_buf_start;
  logic [15:0]                     r_word_cnt;
  logic [15:0]                     r_word_idx;
  logic [3:0]                      r_beat;
  logic [BUF_W-1:0]                r_shift;
  logic                            r_ap_done;
  logic                            r_wr_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_wr_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]    r_wr_size;
  logic                            r_ren;
  logic [12:0]                     r_raddr;
  logic                            r_tvalid;

  logic                            w_accept;
  logic                            w_last_word;
  logic [15:0]                     w_next_idx;
  logic [12:0]                     w_next_addr;
  logic                            w_unused_bits;

  assign w_accept      = r_tvalid & m_axis_tready;
  assign w_last_word   = (r_word_idx == (r_word_cnt - 16'd1));
  assign w_next_idx    = r_word_idx + 16'd1;
  // 13-bit sum gives the mod-8192 buffer wrap for free
  assign w_next_addr   = r_buf_start + w_next_idx[12:0];
  assign w_unused_bits = ^{ctrl_instruction[31:0], ctrl_instruction[47:45]};

  assign ap_done                    = r_ap_done;
  assign save_read_buffer_r_en      = r_ren;
  assign save_read_buffer_r_addr    = r_raddr;
  assign wr_ctrl_start              = r_wr_start;
  assign wr_ctrl_addr_offset        = r_wr_addr;
  assign wr_ctrl_xfer_size_in_bytes = r_wr_size;
  assign m_axis_tvalid              = r_tvalid;
  assign m_axis_tdata               = r_shift[C_M_AXI_DATA_WIDTH-1:0];
  assign m_axis_tlast               = r_tvalid & (r_beat == 4'hF) & w_last_word;

  // Control FSM: latches the instruction, fetches words, shifts out beats, handshakes completion
  always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
    if (!kernel_rst_n) begin
      r_state     <= S_IDLE;
      r_buf_start <= '0;
      r_word_cnt  <= '0;
      r_word_idx  <= '0;
      r_beat      <= '0;
      r_shift     <= '0;
      r_ap_done   <= 1'b0;
      r_wr_start  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_size   <= '0;
      r_ren       <= 1'b0;
      r_raddr     <= '0;
      r_tvalid    <= 1'b0;
    end else begin
      r_wr_start <= 1'b0;
      r_ren      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_buf_start <= ctrl_instruction[44:32];
            r_word_cnt  <= ctrl_instruction[63:48];
            r_word_idx  <= '0;
            r_beat      <= '0;
            r_wr_addr   <= ctrl_addr_offset +
                           {{(C_M_AXI_ADDR_WIDTH-16){1'b0}}, ctrl_instruction[79:64]};
            r_wr_size   <= {{(C_XFER_SIZE_WIDTH-16){1'b0}}, ctrl_instruction[95:80]};
            if (ctrl_instruction[63:48] == 16'd0) begin
              r_state <= S_DONE;
            end else begin
              // LAUNCH doubles as the fetch of the first word
              r_wr_start <= 1'b1;
              r_ren      <= 1'b1;
              r_raddr    <= ctrl_instruction[44:32];
              r_state    <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: r_state <= S_CAPTURE;
        S_FETCH:  r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_shift  <= save_read_buffer_r_data;
          r_tvalid <= 1'b1;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_accept) begin
            r_shift <= {{C_M_AXI_DATA_WIDTH{1'b0}}, r_shift[BUF_W-1:C_M_AXI_DATA_WIDTH]};
            r_beat  <= r_beat + 4'd1;
            if (r_beat == 4'hF) begin
              r_tvalid <= 1'b0;
              if (w_last_word) begin
                r_state <= S_WAIT_WR;
              end else begin
                r_word_idx <= w_next_idx;
                r_raddr    <= w_next_addr;
                r_ren      <= 1'b1;
                r_state    <= S_FETCH;
              end
            end
          end
        end
        S_WAIT_WR: begin
          if (wr_ctrl_done) begin
            r_ap_done <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          // zero-count jobs arrive here with ap_done still low and raise it one cycle later
          if (r_ap_done) begin
            r_ap_done <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_ap_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gnn_0_example_save.sv
// tb/tb_gnn_0_example_save.sv - directed self-checking bench for gnn_0_example_save
module tb_gnn_0_example_save;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 32;
  localparam int IW = 96;
  localparam int BW = 16 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [IW-1:0] ctrl_instruction = '0;
  logic          ren;
  logic [12:0]   raddr;
  logic [BW-1:0] rdata = '0;
  logic          wr_start;
  logic [AW-1:0] wr_addr;
  logic [XW-1:0] wr_size;
  logic          wr_done = 1'b0;
  logic          tvalid;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic          tlast;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rdy_rnd = 1'b0;

  logic [DW-1:0] beat_q[$];
  bit            last_q[$];
  int            beat_cyc_q[$];
  logic [12:0]   raddr_q[$];
  int            ren_cyc_q[$];
  int            n_start, start_cyc, n_done, done_cyc, n_valid;
  logic [AW-1:0] start_addr;
  logic [XW-1:0] start_size;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  gnn_0_example_save dut (
    .kernel_clk                 (clk),
    .kernel_rst_n               (rst_n),
    .ap_start                   (ap_start),
    .ap_done                    (ap_done),
    .ctrl_addr_offset           (ctrl_addr_offset),
    .ctrl_instruction           (ctrl_instruction),
    .save_read_buffer_r_en      (ren),
    .save_read_buffer_r_addr    (raddr),
    .save_read_buffer_r_data    (rdata),
    .wr_ctrl_start              (wr_start),
    .wr_ctrl_addr_offset        (wr_addr),
    .wr_ctrl_xfer_size_in_bytes (wr_size),
    .wr_ctrl_done               (wr_done),
    .m_axis_tvalid              (tvalid),
    .m_axis_tready              (tready),
    .m_axis_tdata               (tdata),
    .m_axis_tlast               (tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] slice_val(input logic [12:0] a, input logic [3:0] k);
    logic [DW-1:0] v;
    for (int l = 0; l < 16; l++) v[32*l +: 32] = {a, k, 4'(l), 3'b101, 8'h3C};
    return v;
  endfunction

  function automatic logic [BW-1:0] word_val(input logic [12:0] a);
    logic [BW-1:0] w;
    for (int k = 0; k < 16; k++) w[DW*k +: DW] = slice_val(a, 4'(k));
    return w;
  endfunction

  function automatic logic [IW-1:0] mk_inst(input logic [15:0] bs, input logic [15:0] cnt,
                                            input logic [15:0] ds, input logic [15:0] bytes);
    return {bytes, ds, cnt, bs, 32'h0};
  endfunction

  // buffer model: one-cycle read latency
  always @(posedge clk) if (ren) rdata <= word_val(raddr);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = rdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (ren) begin raddr_q.push_back(raddr); ren_cyc_q.push_back(cyc); end
    if (wr_start) begin n_start++; start_cyc = cyc; start_addr = wr_addr; start_size = wr_size; end
    if (tvalid) n_valid++;
    if (tvalid && tready) begin
      beat_q.push_back(tdata); last_q.push_back(tlast); beat_cyc_q.push_back(cyc);
    end
    if (ap_done) begin n_done++; done_cyc = cyc; end
    if (prev_stall && rst_n) begin
      checks++;
      if (!(tvalid && tdata == prev_data)) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d tvalid=%0b data changed under stall", cyc, tvalid);
      end
    end
    prev_stall = rst_n && tvalid && !tready;
    prev_data  = tdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    beat_q.delete(); last_q.delete(); beat_cyc_q.delete();
    raddr_q.delete(); ren_cyc_q.delete();
    n_start = 0; n_done = 0; n_valid = 0; start_cyc = -1; done_cyc = -1;
    start_addr = '0; start_size = '0;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 4000 && beat_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [15:0] bs, cnt, ds, bytes;
    logic [63:0] off;
    bit          rnd;
    logic [63:0] exp_addr;
    logic [31:0] exp_size;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int T, n, dcyc, nbad, nlast;
    logic [12:0] wa;
    clear_mon();
    rdy_rnd = v.rnd;
    @(posedge clk); #1;
    ctrl_instruction = mk_inst(v.bs, v.cnt, v.ds, v.bytes);
    ctrl_addr_offset = v.off;
    ap_start = 1'b1;
    T = cyc;
    @(posedge clk); #1;
    ap_start = 1'b0;
    ctrl_instruction = {$urandom, $urandom, $urandom};
    ctrl_addr_offset = ~v.off;
    n = int'(v.cnt) * 16;
    dcyc = -100;
    wait_beats(n);
    if (v.cnt != 0) begin
      repeat (6) @(posedge clk);
      #1;
      wr_done = 1'b1;
      dcyc = cyc;
      @(posedge clk); #1;
      wr_done = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    $display("vector %0d: cnt=%0d beats=%0d", id, v.cnt, beat_q.size());
    chk($sformatf("v%0d_n_start", id), 64'(n_start), 64'(v.cnt != 0));
    chk($sformatf("v%0d_n_ren", id), 64'(raddr_q.size()), 64'(v.cnt));
    chk($sformatf("v%0d_n_beats", id), 64'(beat_q.size()), 64'(n));
    chk($sformatf("v%0d_n_done", id), 64'(n_done), 64'd1);
    if (v.cnt == 0) begin
      chk($sformatf("v%0d_done_cyc", id), 64'(done_cyc), 64'(T + 2));
      chk($sformatf("v%0d_no_tvalid", id), 64'(n_valid), 64'd0);
    end else begin
      chk($sformatf("v%0d_start_cyc", id), 64'(start_cyc), 64'(T + 1));
      chk($sformatf("v%0d_start_addr", id), start_addr, v.exp_addr);
      chk($sformatf("v%0d_start_size", id), 64'(start_size), 64'(v.exp_size));
      chk($sformatf("v%0d_done_cyc", id), 64'(done_cyc), 64'(dcyc + 1));
      if (ren_cyc_q.size() > 0) chk($sformatf("v%0d_ren_cyc", id), 64'(ren_cyc_q[0]), 64'(T + 1));
      for (int i = 0; i < raddr_q.size() && i < int'(v.cnt); i++)
        chk($sformatf("v%0d_raddr%0d", id, i), 64'(raddr_q[i]), 64'(13'(v.bs + 16'(i))));
      nbad = 0;
      nlast = 0;
      for (int b = 0; b < beat_q.size(); b++) begin
        wa = 13'(v.bs + 16'(b / 16));
        checks++;
        if (beat_q[b] !== slice_val(wa, 4'(b % 16))) begin
          errors++;
          $display("FAIL v%0d_beat%0d data act=%h exp=%h", id, b, beat_q[b][63:0], slice_val(wa, 4'(b % 16)) [63:0]);
        end
        if (last_q[b]) nlast++;
        if (!v.rnd && beat_cyc_q[b] != T + 3 + 18 * (b / 16) + (b % 16)) nbad++;
      end
      chk($sformatf("v%0d_n_tlast", id), 64'(nlast), 64'd1);
      if (last_q.size() > 0) chk($sformatf("v%0d_tlast_final", id), 64'(last_q[$]), 64'd1);
      if (!v.rnd) chk($sformatf("v%0d_beat_timing_bad", id), 64'(nbad), 64'd0);
    end
  endtask

  vec_t vecs[4];

  initial begin
    int T, nb, nbad;
    vecs[0] = '{bs:16'h0010, cnt:16'd1, ds:16'h0100, bytes:16'd1024, off:64'h1000,
                rnd:1'b0, exp_addr:64'h1100, exp_size:32'd1024};
    vecs[1] = '{bs:16'h1FFF, cnt:16'd3, ds:16'h0200, bytes:16'd3072, off:64'h1_0000_0000,
                rnd:1'b1, exp_addr:64'h1_0000_0200, exp_size:32'd3072};
    vecs[2] = '{bs:16'h0100, cnt:16'd2, ds:16'hFFFF, bytes:16'd2048, off:64'h20_0000,
                rnd:1'b0, exp_addr:64'h20_FFFF, exp_size:32'd2048};
    vecs[3] = '{bs:16'h0ABC, cnt:16'd0, ds:16'h0040, bytes:16'd0, off:64'h3000,
                rnd:1'b0, exp_addr:64'h0, exp_size:32'd0};

    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_ctrl", 64'({tvalid, tlast, ren, wr_start, ap_done}), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({tvalid, tlast, ren, wr_start, ap_done}), 64'd0);
    chk("rst_addr", wr_addr, 64'd0);
    chk("rst_size_raddr", 64'({wr_size, raddr}), 64'd0);
    chk("rst_tdata_zero", 64'(tdata != '0), 64'd0);
    chk("rst_no_done", 64'(n_done), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // busy protection: second ap_start during SEND is ignored
    clear_mon();
    rdy_rnd = 1'b0;
    @(posedge clk); #1;
    ctrl_instruction = mk_inst(16'h0040, 16'd1, 16'h0000, 16'd1024);
    ctrl_addr_offset = 64'h0;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    wait_beats(3);
    ctrl_instruction = mk_inst(16'h0050, 16'd5, 16'h0010, 16'd5120);
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    wait_beats(16);
    repeat (3) @(posedge clk);
    #1;
    wr_done = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("busy_n_start", 64'(n_start), 64'd1);
    chk("busy_n_ren", 64'(raddr_q.size()), 64'd1);
    chk("busy_n_beats", 64'(beat_q.size()), 64'd16);
    chk("busy_n_done", 64'(n_done), 64'd1);
    nbad = 0;
    for (int b = 0; b < beat_q.size(); b++)
      if (beat_q[b] !== slice_val(13'h0040, 4'(b))) nbad++;
    chk("busy_beat_data_bad", 64'(nbad), 64'd0);

    // reset asserted mid-SEND aborts immediately
    clear_mon();
    @(posedge clk); #1;
    ctrl_instruction = mk_inst(16'h0200, 16'd2, 16'h0000, 16'd2048);
    ap_start = 1'b1;
    T = cyc;
    @(posedge clk); #1;
    ap_start = 1'b0;
    wait_beats(5);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ctrl", 64'({tvalid, tlast, ren, wr_start, ap_done}), 64'd0);
    chk("rstmid_tdata_zero", 64'(tdata != '0), 64'd0);
    chk("rstmid_addr", wr_addr, 64'd0);
    nb = beat_q.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rstmid_no_more_beats", 64'(beat_q.size()), 64'(nb));
    chk("rstmid_no_done", 64'(n_done), 64'd0);
    chk("rstmid_single_ren", 64'(raddr_q.size()), 64'd1);
    chk("rstmid_beats_before", 64'(nb >= 5 && cyc > T), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
